// File: rtl/if1_pc_gen_pkg.sv
// Shared constants, 2-bit counter encodings and saturating counter helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if1_pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h1c00_0000;
    localparam int          BTB_IDX_W_DEFAULT = 4;

    // Bit 1 of the counter is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic ctr_e ctr_inc(input ctr_e c);
        case (c)
            CTR_SNT: ctr_inc = CTR_WNT;
            CTR_WNT: ctr_inc = CTR_WT;
            default: ctr_inc = CTR_ST;
        endcase
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        case (c)
            CTR_ST:  ctr_dec = CTR_WT;
            CTR_WT:  ctr_dec = CTR_WNT;
            default: ctr_dec = CTR_SNT;
        endcase
    endfunction

endpackage

// File: rtl/if1_pc_gen_if.sv
// Bundle of hazard-control redirect, EX training and IF1 fetch/prediction signals.
// Latency: n/a (wires only).
// Backpressure: pc_wen=0 stalls the fetch PC; training has no backpressure.
interface if1_pc_gen_if;

    logic        pc_wen;
    logic        pc_is_wrong;
    logic [31:0] pc_correct;
    logic        ex_upd_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_branch;
    logic [31:0] ex_pc_branch;
    logic [31:0] if1_pc;
    logic        if1_branch_bp;
    logic [31:0] if1_pc_bp;
    logic [31:0] bp_miss_cnt;

    modport master (
        output pc_wen, pc_is_wrong, pc_correct,
        output ex_upd_valid, ex_is_branch, ex_pc, ex_branch, ex_pc_branch,
        input  if1_pc, if1_branch_bp, if1_pc_bp, bp_miss_cnt
    );

    modport slave (
        input  pc_wen, pc_is_wrong, pc_correct,
        input  ex_upd_valid, ex_is_branch, ex_pc, ex_branch, ex_pc_branch,
        output if1_pc, if1_branch_bp, if1_pc_bp, bp_miss_cnt
    );

endinterface

// File: rtl/if1_pc_gen_bp_btb.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup, EX-trained update.
// Latency: lookup 0 cycles; an update is visible to lookup the cycle after its edge.
// Backpressure: none; an update is applied on every edge where upd_vld is high.
module bp_btb
    import if1_pc_gen_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] lk_pc,
    output logic        lk_taken,
    output logic [31:0] lk_target,
    input  logic        upd_vld,
    input  logic        upd_is_branch,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    ctr_e               ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign lk_idx    = lk_pc[IDX_W+1:2];
    assign lk_tag    = lk_pc[31:IDX_W+2];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ctr_q[lk_idx][1];
    assign lk_target = tgt_q[lk_idx];

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Valid bits and counters: reset clears them, so stale tags/targets are harmless.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_SNT;
            end
        end else if (upd_vld) begin
            if (upd_is_branch) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= upd_taken ? ctr_inc(ctr_q[upd_idx]) : ctr_dec(ctr_q[upd_idx]);
                end else if (upd_taken) begin
                    valid_q[upd_idx] <= 1'b1;
                    ctr_q[upd_idx]   <= CTR_WT;
                end
            end else if (upd_hit) begin
                // A non-branch matched this entry: it is an alias, drop it.
                valid_q[upd_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload: written on every taken branch (allocate or refresh).
    always_ff @(posedge clk) begin
        if (upd_vld && upd_is_branch && upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/if1_pc_gen.sv
// Fetch PC register, next-PC mux with redirect, BTB prediction and redirect counter.
// Latency: prediction 0 cycles after if1_pc; redirect/next PC appear one edge later.
// Backpressure: pc_wen=0 holds the PC and drops any concurrent redirect; training continues.
module if1_pc_gen
    import if1_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    if1_pc_gen_if.slave  bus
);

    logic [31:0] pc_q;
    logic [31:0] miss_cnt_q;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic [31:0] pc_bp;

    bp_btb #(
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk           (clk),
        .resetn        (resetn),
        .lk_pc         (pc_q),
        .lk_taken      (bp_taken),
        .lk_target     (bp_target),
        .upd_vld       (bus.ex_upd_valid),
        .upd_is_branch (bus.ex_is_branch),
        .upd_pc        (bus.ex_pc),
        .upd_taken     (bus.ex_branch),
        .upd_target    (bus.ex_pc_branch)
    );

    assign pc_bp = bp_taken ? bp_target : pc_q + 32'd4;

    // Fetch PC: stall beats redirect, redirect beats prediction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q <= RESET_PC;
        end else if (bus.pc_wen) begin
            pc_q <= bus.pc_is_wrong ? bus.pc_correct : pc_bp;
        end
    end

    // Count only redirects that are actually accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            miss_cnt_q <= '0;
        end else if (bus.pc_wen && bus.pc_is_wrong) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.if1_pc        = pc_q;
    assign bus.if1_branch_bp = bp_taken;
    assign bus.if1_pc_bp     = pc_bp;
    assign bus.bp_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_if1_pc_gen.sv
// Directed-vector bench for if1_pc_gen with a queue-based scoreboard.
// Latency: each row's expectation describes outputs during that cycle.
// Backpressure: stall rows exercise pc_wen=0 including ignored redirects.
module tb_if1_pc_gen;

    logic clk;
    logic resetn;
    if1_pc_gen_if bus();

    if1_pc_gen #(
        .RESET_PC  (32'h1c00_0000),
        .BTB_IDX_W (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          row;
        logic [31:0] pc;
        logic        bp;
        logic [31:0] pcbp;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   row_no   = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", nm, row, act, expv);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; pop one expectation per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("if1_pc",        e.row, bus.if1_pc,               e.pc);
            chk("if1_branch_bp", e.row, {31'd0, bus.if1_branch_bp}, {31'd0, e.bp});
            chk("if1_pc_bp",     e.row, bus.if1_pc_bp,            e.pcbp);
            chk("bp_miss_cnt",   e.row, bus.bp_miss_cnt,          e.cnt);
        end
    end

    // One cycle: drive inputs just after the edge and queue the outputs expected in this cycle.
    task automatic cyc(
        input logic rst_v, input logic wen, input logic wrong, input logic [31:0] correct,
        input logic upd, input logic isbr, input logic [31:0] expc, input logic br, input logic [31:0] tgt,
        input logic [31:0] e_pc, input logic e_bp, input logic [31:0] e_pcbp, input logic [31:0] e_cnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        resetn           = rst_v;
        bus.pc_wen       = wen;
        bus.pc_is_wrong  = wrong;
        bus.pc_correct   = correct;
        bus.ex_upd_valid = upd;
        bus.ex_is_branch = isbr;
        bus.ex_pc        = expc;
        bus.ex_branch    = br;
        bus.ex_pc_branch = tgt;
        row_no++;
        e.row  = row_no;
        e.pc   = e_pc;
        e.bp   = e_bp;
        e.pcbp = e_pcbp;
        e.cnt  = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog row=%0d actual=timeout expected=finish", row_no);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn           = 1'b0;
        bus.pc_wen       = 1'b0;
        bus.pc_is_wrong  = 1'b0;
        bus.pc_correct   = '0;
        bus.ex_upd_valid = 1'b0;
        bus.ex_is_branch = 1'b0;
        bus.ex_pc        = '0;
        bus.ex_branch    = 1'b0;
        bus.ex_pc_branch = '0;

        // Reset state, then sequential fetch.
        cyc(0,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000000,0,32'h1c000004,0);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000000,0,32'h1c000004,0);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000004,0,32'h1c000008,0);
        // Stall, with a redirect that must be ignored.
        cyc(1,0,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000008,0,32'h1c00000c,0);
        cyc(1,0,1,32'h1c000200,  0,0,32'h0,0,32'h0,  32'h1c000008,0,32'h1c00000c,0);
        // Accepted redirect.
        cyc(1,1,1,32'h1c000100,  0,0,32'h0,0,32'h0,  32'h1c000008,0,32'h1c00000c,0);
        // Train taken while stalled; lookup still sees the empty entry this cycle.
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,1,32'h1c000040,  32'h1c000100,0,32'h1c000104,1);
        cyc(1,0,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000100,1,32'h1c000040,1);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000100,1,32'h1c000040,1);
        // Predicted target fetched; train not-taken (ctr 10 -> 01).
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,0,32'h0,  32'h1c000040,0,32'h1c000044,1);
        cyc(1,1,1,32'h1c000100,  0,0,32'h0,0,32'h0,  32'h1c000040,0,32'h1c000044,1);
        // ctr 01 predicts not taken; second drop saturates at 00.
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,0,32'h0,  32'h1c000100,0,32'h1c000104,2);
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,1,32'h1c000040,  32'h1c000100,0,32'h1c000104,2);
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,1,32'h1c000040,  32'h1c000100,0,32'h1c000104,2);
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,1,32'h1c000040,  32'h1c000100,1,32'h1c000040,2);
        // ctr 11 saturates; target refreshed to 1c000080.
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,1,32'h1c000080,  32'h1c000100,1,32'h1c000040,2);
        cyc(1,0,0,32'h0,  1,1,32'h1c000100,0,32'h0,  32'h1c000100,1,32'h1c000080,2);
        // Aliased non-branch (same index, other tag): no change.
        cyc(1,0,0,32'h0,  1,0,32'h1c000140,0,32'h0,  32'h1c000100,1,32'h1c000080,2);
        cyc(1,0,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000100,1,32'h1c000080,2);
        // Non-branch hit invalidates the entry.
        cyc(1,0,0,32'h0,  1,0,32'h1c000100,0,32'h0,  32'h1c000100,1,32'h1c000080,2);
        cyc(1,0,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000100,0,32'h1c000104,2);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000100,0,32'h1c000104,2);
        // Redirect and allocate in the same cycle.
        cyc(1,1,1,32'h1c000300,  1,1,32'h1c000300,1,32'h1c000000,  32'h1c000104,0,32'h1c000108,2);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000300,1,32'h1c000000,3);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000000,0,32'h1c000004,3);
        // Mid-run reset with a valid entry at 1c000300.
        cyc(0,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000000,0,32'h1c000004,0);
        cyc(1,1,1,32'h1c000300,  0,0,32'h0,0,32'h0,  32'h1c000000,0,32'h1c000004,0);
        cyc(1,0,0,32'h0,         0,0,32'h0,0,32'h0,  32'h1c000300,0,32'h1c000304,1);
        // +4 wraps modulo 2^32.
        cyc(1,1,1,32'hfffffffc,  0,0,32'h0,0,32'h0,  32'h1c000300,0,32'h1c000304,1);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'hfffffffc,0,32'h00000000,2);
        cyc(1,1,0,32'h0,         0,0,32'h0,0,32'h0,  32'h00000000,0,32'h00000004,2);

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drain", row_no, exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
